// File: rtl/nlc_pkg.sv
// Shared types for the nested loop counter: accumulator lifetime mode and sequencer states.
package nlc_pkg;

   typedef enum logic {
      MODE_AUTO   = 1'b0,
      MODE_STATIC = 1'b1
   } nlc_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } nlc_state_e;

endpackage

// File: rtl/nlc_idx_ctr.sv
// Two-level index counter, inner index fastest, wrapping to (0,0) after the last beat.
// Flags describe the current beat (last_beat) and the beat that follows it (first_inner).
module nlc_idx_ctr #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             advance,
   input  logic [CNT_W-1:0] outer_n,
   input  logic [CNT_W-1:0] inner_n,
   output logic [CNT_W-1:0] outer_idx,
   output logic [CNT_W-1:0] inner_idx,
   output logic             first_inner,
   output logic             last_beat
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             inner_last;
   logic             outer_last;
   logic [CNT_W-1:0] nxt_outer;
   logic [CNT_W-1:0] nxt_inner;

   // first_inner tells the accumulator that the next beat opens a new outer iteration
   always_comb begin
      inner_last  = (inner_idx == inner_n - CNT_ONE);
      outer_last  = (outer_idx == outer_n - CNT_ONE);
      last_beat   = inner_last && outer_last;
      nxt_inner   = inner_last ? '0 : inner_idx + CNT_ONE;
      nxt_outer   = outer_idx;
      if (inner_last) begin
         nxt_outer = outer_last ? '0 : outer_idx + CNT_ONE;
      end
      first_inner = (nxt_inner == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outer_idx <= '0;
         inner_idx <= '0;
      end else if (clear) begin
         outer_idx <= '0;
         inner_idx <= '0;
      end else if (advance) begin
         outer_idx <= nxt_outer;
         inner_idx <= nxt_inner;
      end
   end

endmodule

// File: rtl/nested_loop_counter.sv
// Two-level loop sequencer streaming an accumulator over valid/ready, automatic or static lifetime.
// Define NLC_TRACE_EN to print every transferred beat during simulation.
module nested_loop_counter
   import nlc_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int CNT_W    = 4,
   parameter int INIT_VAL = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              mode,
   input  logic [CNT_W-1:0]  outer_n,
   input  logic [CNT_W-1:0]  inner_n,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_outer_idx,
   output logic [CNT_W-1:0]  out_inner_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [DATA_W-1:0] INIT_D   = DATA_W'(INIT_VAL);
   localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

   nlc_state_e       state;
   nlc_mode_e        mode_q;
   logic [CNT_W-1:0] outer_q;
   logic [CNT_W-1:0] inner_q;
   logic             start_go;
   logic             transfer;
   logic             first_inner;
   logic             last_beat;

   assign start_go = (state == IDLE) && start;
   assign transfer = out_valid && out_ready;

   nlc_idx_ctr #(
      .CNT_W(CNT_W)
   ) u_idx_ctr (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_go),
      .advance    (transfer),
      .outer_n    (outer_q),
      .inner_n    (inner_q),
      .outer_idx  (out_outer_idx),
      .inner_idx  (out_inner_idx),
      .first_inner(first_inner),
      .last_beat  (last_beat)
   );

   // out_data doubles as the accumulator, so each beat already carries the incremented value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         mode_q    <= MODE_AUTO;
         outer_q   <= '0;
         inner_q   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mode_q  <= nlc_mode_e'(mode);
                  outer_q <= outer_n;
                  inner_q <= inner_n;
                  if ((outer_n != '0) && (inner_n != '0)) begin
                     state     <= RUN;
                     busy      <= 1'b1;
                     out_valid <= 1'b1;
                     out_data  <= INIT_D + DATA_ONE;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (transfer) begin
                  if (last_beat) begin
                     state     <= DONE;
                     busy      <= 1'b0;
                     out_valid <= 1'b0;
                     out_data  <= '0;
                     done      <= 1'b1;
                  end else if ((mode_q == MODE_AUTO) && first_inner) begin
                     out_data <= INIT_D + DATA_ONE;
                  end else begin
                     out_data <= out_data + DATA_ONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef NLC_TRACE_EN
   always @(posedge clk) begin
      if (!rst && transfer) begin
         $display("nlc mode=%0d outer=%0d inner=%0d data=%0d",
                  mode_q, out_outer_idx, out_inner_idx, out_data);
      end
   end
`else
`endif

endmodule

// File: tb/tb_nested_loop_counter.sv
// Directed bench for nested_loop_counter: an 8-bit instance for the main runs, a 4-bit one for wrap.
module tb_nested_loop_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8;
   logic       start4;
   logic       mode;
   logic [3:0] outerN;
   logic [3:0] innerN;
   logic       outReady;

   logic       valid8, busy8, done8;
   logic [7:0] data8;
   logic [3:0] oIdx8, iIdx8;
   logic       valid4, busy4, done4;
   logic [3:0] data4;
   logic [3:0] oIdx4, iIdx4;

   int checkCount = 0;
   int failCount  = 0;

   always #5 clk = ~clk;

   nested_loop_counter #(.DATA_W(8), .CNT_W(4), .INIT_VAL(0)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .mode(mode),
      .outer_n(outerN), .inner_n(innerN),
      .out_valid(valid8), .out_ready(outReady), .out_data(data8),
      .out_outer_idx(oIdx8), .out_inner_idx(iIdx8),
      .busy(busy8), .done(done8)
   );

   nested_loop_counter #(.DATA_W(4), .CNT_W(4), .INIT_VAL(0)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .mode(mode),
      .outer_n(outerN), .inner_n(innerN),
      .out_valid(valid4), .out_ready(outReady), .out_data(data4),
      .out_outer_idx(oIdx4), .out_inner_idx(iIdx4),
      .busy(busy4), .done(done4)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sampleObs(input logic sel4, output logic v, output logic [7:0] d,
                            output logic [3:0] oi, output logic [3:0] ii,
                            output logic b, output logic dn);
      v  = sel4 ? valid4 : valid8;
      d  = sel4 ? {4'h0, data4} : data8;
      oi = sel4 ? oIdx4 : oIdx8;
      ii = sel4 ? iIdx4 : iIdx8;
      b  = sel4 ? busy4 : busy8;
      dn = sel4 ? done4 : done8;
   endtask

   // Pulses start for one cycle; returns at the first negedge after start was sampled
   task automatic applyStimulus(input logic sel4, input logic m, input logic [3:0] o, input logic [3:0] i);
      @(negedge clk);
      mode   = m;
      outerN = o;
      innerN = i;
      if (sel4) start4 = 1'b1;
      else start8 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      start8 = 1'b0;
   endtask

   task automatic checkRun(input string tag, input logic sel4, input logic m, input int o, input int i,
                           input int stallBeat, input int stallLen, input logic holdStart);
      logic v, b, dn;
      logic [7:0] d;
      logic [3:0] oi, ii;
      int n = o * i;
      int mask = sel4 ? 32'h0f : 32'hff;
      int acc = 0;
      int k = 0;
      int stalls = 0;
      int expO, expI;
      applyStimulus(sel4, m, 4'(o), 4'(i));
      sampleObs(sel4, v, d, oi, ii, b, dn);
      checkOutput({tag, ".busyRise"}, 32'(b), 1);
      if (holdStart) begin
         start8 = 1'b1;
         mode   = ~m;
         outerN = 4'd1;
         innerN = 4'd1;
      end
      expO = 0;
      expI = 0;
      acc  = 1;
      while (k < n) begin
         sampleObs(sel4, v, d, oi, ii, b, dn);
         checkOutput($sformatf("%s.valid%0d", tag, k), 32'(v), 1);
         checkOutput($sformatf("%s.data%0d", tag, k), 32'(d), 32'(acc));
         checkOutput($sformatf("%s.outer%0d", tag, k), 32'(oi), 32'(expO));
         checkOutput($sformatf("%s.inner%0d", tag, k), 32'(ii), 32'(expI));
         if (k == stallBeat && stalls < stallLen) begin
            outReady = 1'b0;
            stalls++;
         end else begin
            outReady = 1'b1;
            k++;
            if (k < n) begin
               expO = k / i;
               expI = k % i;
               if (m == 1'b0 && expI == 0) acc = 0;
               acc = (acc + 1) & mask;
            end
         end
         @(negedge clk);
      end
      outReady = 1'b1;
      sampleObs(sel4, v, d, oi, ii, b, dn);
      checkOutput({tag, ".donePulse"}, 32'(dn), 1);
      checkOutput({tag, ".busyFall"}, 32'(b), 0);
      checkOutput({tag, ".validFall"}, 32'(v), 0);
      checkOutput({tag, ".idxClear"}, 32'({oi, ii}), 0);
      @(negedge clk);
      sampleObs(sel4, v, d, oi, ii, b, dn);
      checkOutput({tag, ".doneEnd"}, 32'(dn), 0);
      if (holdStart) begin
         start8 = 1'b0;
         @(negedge clk);
         sampleObs(sel4, v, d, oi, ii, b, dn);
         checkOutput({tag, ".noQueuedValid"}, 32'(v), 0);
         checkOutput({tag, ".noQueuedBusy"}, 32'(b), 0);
      end
   endtask

   task automatic zeroRun(input string tag, input logic [3:0] o, input logic [3:0] i);
      applyStimulus(1'b0, 1'b0, o, i);
      checkOutput({tag, ".done"}, 32'(done8), 1);
      checkOutput({tag, ".valid"}, 32'(valid8), 0);
      checkOutput({tag, ".busy"}, 32'(busy8), 0);
      @(negedge clk);
      checkOutput({tag, ".doneEnd"}, 32'(done8), 0);
      checkOutput({tag, ".validEnd"}, 32'(valid8), 0);
   endtask

   initial begin
      rst      = 1'b1;
      start8   = 1'b0;
      start4   = 1'b0;
      mode     = 1'b0;
      outerN   = 4'd0;
      innerN   = 4'd0;
      outReady = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset.valid", 32'(valid8), 0);
      checkOutput("reset.data", 32'(data8), 0);
      checkOutput("reset.idx", 32'({oIdx8, iIdx8}), 0);
      checkOutput("reset.busy", 32'(busy8), 0);
      checkOutput("reset.done", 32'(done8), 0);
      checkOutput("reset.valid4", 32'(valid4), 0);
      rst = 1'b0;

      checkRun("auto3x3", 1'b0, 1'b0, 3, 3, -1, 0, 1'b0);
      checkRun("static3x3", 1'b0, 1'b1, 3, 3, -1, 0, 1'b0);
      checkRun("stall2x2", 1'b0, 1'b1, 2, 2, 1, 3, 1'b0);
      checkRun("wrap4x5", 1'b1, 1'b1, 4, 5, -1, 0, 1'b0);
      zeroRun("zeroOuter", 4'd0, 4'd3);
      zeroRun("zeroInner", 4'd2, 4'd0);
      checkRun("startWhileBusy", 1'b0, 1'b0, 2, 3, -1, 0, 1'b1);

      // Reset lands while the fifth beat of an automatic 3x3 run is on the bus
      applyStimulus(1'b0, 1'b0, 4'd3, 4'd3);
      repeat (4) @(negedge clk);
      checkOutput("midReset.beat5", 32'(data8), 2);
      rst = 1'b1;
      #1;
      checkOutput("midReset.valid", 32'(valid8), 0);
      checkOutput("midReset.data", 32'(data8), 0);
      checkOutput("midReset.idx", 32'({oIdx8, iIdx8}), 0);
      checkOutput("midReset.busy", 32'(busy8), 0);
      @(negedge clk);
      checkOutput("midReset.noDone", 32'(done8), 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midReset.noDoneAfter", 32'(done8), 0);
      checkOutput("midReset.idle", 32'(valid8), 0);
      checkRun("afterReset", 1'b0, 1'b0, 3, 3, -1, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/nested_loop_counter.md
# nested_loop_counter

Two-level loop sequencer emitting an accumulator stream over a valid/ready interface. Generalises the static versus automatic loop-variable lifetime behaviour into hardware: a run-time mode chooses whether the accumulator re-initialises at the start of each outer iteration (automatic) or only once per run (static). Width, initial value and loop bounds are parametrised. Used as a deterministic stimulus source and scoreboard reference in the assertion and trace benches.

## Interface
- DATA_W, 8: accumulator and out_data width.
- CNT_W, 4: width of the loop-bound inputs and the index outputs.
- INIT_VAL, 0: accumulator initial value, truncated to DATA_W.

- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous and active-high.
- start  in  1  run request; sampled only in IDLE.
- mode  in  1  0 = automatic (re-initialise per outer iteration), 1 = static (initialise once per run); latched on start.
- outer_n  in  CNT_W  outer iteration count; latched on start.
- inner_n  in  CNT_W  inner iteration count; latched on start.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  DATA_W  accumulator value after the increment.
- out_outer_idx  out  CNT_W  outer index of the current beat.
- out_inner_idx  out  CNT_W  inner index of the current beat.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at the end of a run.

## Operation
- States:
  - IDLE -> RUN on start, when outer_n != 0 and inner_n != 0.
  - IDLE -> DONE on start, when either bound is 0. No beats are emitted.
  - RUN -> DONE when the last beat (outer_n-1, inner_n-1) is accepted.
  - DONE -> IDLE unconditionally.
- Each beat does the increment first, then outputs: acc = acc + 1, and out_data is the new acc.
- Automatic mode: acc is loaded with INIT_VAL at inner index 0 of every outer iteration, so the first beat of each outer iteration is INIT_VAL+1.
- Static mode: acc is loaded with INIT_VAL only on start. Values accumulate across outer iterations.
- Arithmetic is modulo 2^DATA_W, so the accumulator wraps silently.
- The index counters run inner-fastest. Both return to 0 when the run ends.
- A beat transfers on out_valid && out_ready. The accumulator and indices advance only on a transfer.

## Timing
- Reset values: out_valid=0, out_data=0, both indices=0, busy=0, done=0, state=IDLE.
- Start latency: the first beat has out_valid=1 in the cycle after start is sampled. busy rises in that same cycle.
- Throughput: one beat per cycle while out_ready=1.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_data and both indices stay stable.
  - out_valid never drops without a transfer.
- done is asserted in the cycle after the final transfer. busy=0 in that same cycle.
- Zero-bound run: done is asserted in the cycle after start, with no out_valid.
- start is ignored in RUN and in DONE. A start sampled in DONE is not queued.
- Bound inputs and mode that change during a run have no effect until the next start.
- Reset mid-run: all outputs go to their reset values immediately. No done pulse is produced.

## Configuration
- NLC_TRACE_EN defined: on every transfer, a simulation-only $display prints mode, outer index, inner index and out_data in decimal.
- NLC_TRACE_EN undefined: no display code is compiled. RTL behaviour is identical in both cases.

## Structure
- Package nlc_pkg holds:
  - the nlc_mode_e typedef: MODE_AUTO=1'b0, MODE_STATIC=1'b1;
  - the nlc_state_e typedef: IDLE, RUN, DONE.
- Sub-module nlc_idx_ctr: the two-level index counter (CNT_W). It produces the first_inner flag (inner index 0) and the last_beat flag.
- The top level holds the FSM, the accumulator, the registered outputs and the trace block.

## Test plan
- Automatic mode, outer_n=3, inner_n=3, INIT_VAL=0, out_ready=1 -> out_data sequence 1 2 3 1 2 3 1 2 3 on consecutive cycles, then done one cycle after the last beat.
- Static mode, 3x3 -> sequence 1 2 3 4 5 6 7 8 9, with indices (0,0)..(2,2) inner-fastest.
- Backpressure: static 2x2 with out_ready low for 3 cycles at the second beat -> out_data=2 and indices (0,1) held stable throughout, then the sequence completes as 1 2 3 4.
- Wrap: DATA_W=4, static, outer_n=4, inner_n=5 -> 1..15, then 0 1 2 3 4 (20 beats).
- Zero bound: outer_n=0 -> no out_valid, and done is asserted the cycle after start. A start issued while busy is ignored.
- Reset mid-run: assert rst during the 5th beat of a 3x3 run -> outputs go to 0 at once and no done pulse appears. A new start afterwards reproduces the full sequence.
